// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR write arbiter: FSM state encoding,
// default widths and a one-hot to index helper.
package ddr_arb_pkg;

  localparam int unsigned SLAVE_NUM_DEF = 4;
  localparam int unsigned ADDR_W_DEF    = 23;
  localparam int unsigned LEN_W_DEF     = 10;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned MAX_SLAVES    = 16;
  localparam int unsigned IDX_W         = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    ISSUE    = 2'd2,
    BURST    = 2'd3
  } arb_state_e;

  // OR of the indices of all set bits; exact for a one-hot or zero input.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_SLAVES-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_SLAVES); i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ddr_wr_arbiter_if.sv
// Slave-FIFO and DDR-controller side signals of the write arbiter.
// master = arbiter view, slave = environment view.
interface ddr_wr_arbiter_if
  import ddr_arb_pkg::*;
#(
  parameter int unsigned SLAVE_NUM = SLAVE_NUM_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) ();

  logic [SLAVE_NUM-1:0]        slave_req;
  logic [SLAVE_NUM*ADDR_W-1:0] slave_waddr;
  logic [SLAVE_NUM*LEN_W-1:0]  slave_wlen;
  logic [SLAVE_NUM*DATA_W-1:0] slave_data;
  logic [SLAVE_NUM-1:0]        slave_ren;
  logic [SLAVE_NUM-1:0]        slave_valid;
  logic                        ready;
  logic                        mem_wen;
  logic                        mem_wen_valid;
  logic [ADDR_W-1:0]           arb_wddr_addr;
  logic [LEN_W-1:0]            arb_wddr_len;
  logic                        ddr_rfifo_en;
  logic [DATA_W-1:0]           ddr_rfifo_data;
  logic                        ddr_write_finish;

  modport master (
    input  slave_req, slave_waddr, slave_wlen, slave_data,
    input  ready, mem_wen_valid, ddr_rfifo_en, ddr_write_finish,
    output slave_ren, slave_valid, mem_wen, arb_wddr_addr, arb_wddr_len, ddr_rfifo_data
  );

  modport slave (
    output slave_req, slave_waddr, slave_wlen, slave_data,
    output ready, mem_wen_valid, ddr_rfifo_en, ddr_write_finish,
    input  slave_ren, slave_valid, mem_wen, arb_wddr_addr, arb_wddr_len, ddr_rfifo_data
  );

endinterface

// File: rtl/arb_rr_picker.sv
// Combinational picker: first eligible slave at or after i_start, wrapping.
// Fixed priority is simply i_start = 0.
module arb_rr_picker
  import ddr_arb_pkg::*;
#(
  parameter int unsigned SLAVE_NUM = SLAVE_NUM_DEF
) (
  input  logic [SLAVE_NUM-1:0] i_eligible,
  input  logic [IDX_W-1:0]     i_start,
  output logic [SLAVE_NUM-1:0] o_grant_c,
  output logic [IDX_W-1:0]     o_idx_c
);

  logic [SLAVE_NUM-1:0] w_grant;

  always_comb begin
    int unsigned pos;
    logic        found;
    w_grant = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < SLAVE_NUM; k++) begin
      pos = (32'(i_start) + k) % SLAVE_NUM;
      if (!found && i_eligible[pos]) begin
        w_grant[pos] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign o_grant_c = w_grant;
  assign o_idx_c   = onehot_to_idx(MAX_SLAVES'(w_grant));

endmodule

// File: rtl/ddr_wr_arbiter.sv
// N-channel write arbiter between slave write FIFOs and the DDR write controller.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module ddr_wr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned SLAVE_NUM = SLAVE_NUM_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input logic              ddr_clk,
  input logic              sys_rstn,
  ddr_wr_arbiter_if.master bus
);

  localparam int unsigned CNT_W = LEN_W + 1;

  arb_state_e           r_state,    w_state_nxt;
  logic [SLAVE_NUM-1:0] r_valid,    w_valid_nxt;
  logic [ADDR_W-1:0]    r_addr,     w_addr_nxt;
  logic [LEN_W-1:0]     r_len,      w_len_nxt;
  logic                 r_mem_wen,  w_mem_wen_nxt;
  logic [CNT_W-1:0]     r_beat_cnt, w_beat_cnt_nxt;

  logic [SLAVE_NUM-1:0] w_eligible;
  logic [SLAVE_NUM-1:0] w_win;
  logic [IDX_W-1:0]     w_win_idx;
  logic [IDX_W-1:0]     w_start;
  logic [ADDR_W-1:0]    w_win_addr;
  logic [LEN_W-1:0]     w_win_len;
  logic                 w_grant;
  logic                 w_ren;
  logic [DATA_W-1:0]    w_rdata;

  // Zero-length requests are never eligible.
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < int'(SLAVE_NUM); i++) begin
      w_eligible[i] = bus.slave_req[i] && (bus.slave_wlen[i*LEN_W +: LEN_W] != '0);
    end
  end

  arb_rr_picker #(.SLAVE_NUM(SLAVE_NUM)) u_picker (
    .i_eligible (w_eligible),
    .i_start    (w_start),
    .o_grant_c  (w_win),
    .o_idx_c    (w_win_idx)
  );

  always_comb begin
    w_win_addr = '0;
    w_win_len  = '0;
    for (int i = 0; i < int'(SLAVE_NUM); i++) begin
      if (w_win_idx == IDX_W'(i)) begin
        w_win_addr = bus.slave_waddr[i*ADDR_W +: ADDR_W];
        w_win_len  = bus.slave_wlen[i*LEN_W +: LEN_W];
      end
    end
  end

  assign w_grant = (r_state == IDLE) && (|w_eligible);

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_last;

  // Last-winner pointer; reset value makes slave 0 the first to be searched.
  always_ff @(posedge ddr_clk) begin
    if (!sys_rstn)    r_last <= IDX_W'(SLAVE_NUM - 1);
    else if (w_grant) r_last <= w_win_idx;
  end

  assign w_start = (r_last >= IDX_W'(SLAVE_NUM - 1)) ? '0 : r_last + 1'b1;
`else
  assign w_start = '0;
`endif

  // A pull strobe beyond the latched length is dropped and not counted.
  assign w_ren = (r_state == BURST) && bus.ddr_rfifo_en && (r_beat_cnt < {1'b0, r_len});

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < int'(SLAVE_NUM); i++) begin
      if (r_valid[i]) w_rdata = w_rdata | bus.slave_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_valid_nxt    = r_valid;
    w_addr_nxt     = r_addr;
    w_len_nxt      = r_len;
    w_mem_wen_nxt  = r_mem_wen;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_valid_nxt    = w_win;
          w_addr_nxt     = w_win_addr;
          w_len_nxt      = w_win_len;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.ready) begin
          w_mem_wen_nxt = 1'b1;
          w_state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_wen_valid) begin
          w_mem_wen_nxt = 1'b0;
          w_state_nxt   = BURST;
        end
      end
      BURST: begin
        if (w_ren && (r_beat_cnt != '1)) w_beat_cnt_nxt = r_beat_cnt + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Finish overrides everything else, including a same-cycle command accept.
    if ((r_state != IDLE) && bus.ddr_write_finish) begin
      w_state_nxt    = IDLE;
      w_valid_nxt    = '0;
      w_addr_nxt     = '0;
      w_len_nxt      = '0;
      w_mem_wen_nxt  = 1'b0;
      w_beat_cnt_nxt = '0;
    end
  end

  always_ff @(posedge ddr_clk) begin
    if (!sys_rstn) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_mem_wen  <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_addr     <= w_addr_nxt;
      r_len      <= w_len_nxt;
      r_mem_wen  <= w_mem_wen_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign bus.slave_valid    = r_valid;
  assign bus.slave_ren      = r_valid & {SLAVE_NUM{w_ren}};
  assign bus.mem_wen        = r_mem_wen;
  assign bus.arb_wddr_addr  = r_addr;
  assign bus.arb_wddr_len   = r_len;
  assign bus.ddr_rfifo_data = w_rdata;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Self-checking bench for ddr_wr_arbiter (4 slaves, default widths).
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_ddr_wr_arbiter;

  logic ddr_clk;
  logic sys_rstn;
  int   n_checks;
  int   n_fail;

  ddr_wr_arbiter_if #(.SLAVE_NUM(4), .ADDR_W(23), .LEN_W(10), .DATA_W(32)) bus ();

  ddr_wr_arbiter #(.SLAVE_NUM(4), .ADDR_W(23), .LEN_W(10), .DATA_W(32)) dut (
    .ddr_clk  (ddr_clk),
    .sys_rstn (sys_rstn),
    .bus      (bus)
  );

  initial ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic        wval;
    logic        rfen;
    logic        fin;
    logic [3:0]  e_valid;
    logic [3:0]  e_ren;
    logic        e_wen;
    logic [22:0] e_addr;
    logic [9:0]  e_len;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [3:0] req, input logic rdy, input logic wval,
                              input logic rfen, input logic fin, input logic [3:0] e_valid,
                              input logic [3:0] e_ren, input logic e_wen,
                              input logic [22:0] e_addr, input logic [9:0] e_len,
                              input logic [31:0] e_data);
    vec_t v;
    v.req = req; v.rdy = rdy; v.wval = wval; v.rfen = rfen; v.fin = fin;
    v.e_valid = e_valid; v.e_ren = e_ren; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_len = e_len; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge ddr_clk);
  endtask

  task automatic clr_inputs();
    bus.slave_req        = '0;
    bus.ready            = 1'b0;
    bus.mem_wen_valid    = 1'b0;
    bus.ddr_rfifo_en     = 1'b0;
    bus.ddr_write_finish = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    sys_rstn = 1'b0;
    cyc();
    sys_rstn = 1'b1;
  endtask

  // Wait for a grant, check it, then walk the command handshake into BURST.
  task automatic reach_burst(input logic [3:0] exp_oh, input string nm);
    int n;
    n = 0;
    do begin
      smp();
      n++;
    end while (bus.slave_valid == 4'b0 && n < 40);
    chk(nm, 64'(bus.slave_valid), 64'(exp_oh));
    n = 0;
    while (!bus.mem_wen && n < 40) begin
      smp();
      n++;
    end
    chk({nm, "_wen"}, 64'(bus.mem_wen), 64'(1'b1));
    bus.mem_wen_valid = 1'b1;
    cyc();
    bus.mem_wen_valid = 1'b0;
  endtask

  task automatic finish_burst(input string nm);
    bus.ddr_write_finish = 1'b1;
    cyc();
    bus.ddr_write_finish = 1'b0;
    chk({nm, "_fin_valid"}, 64'(bus.slave_valid), 64'(4'b0));
  endtask

  initial begin
    logic [3:0] exp_oh;
    int         n_ren;
    int         bad;

    n_checks = 0;
    n_fail   = 0;
    clr_inputs();
    bus.slave_waddr = {23'h3000, 23'h1000, 23'h0800, 23'h0400};
    bus.slave_wlen  = {10'd4, 10'd8, 10'd6, 10'd5};
    bus.slave_data  = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

    // Reset values with every slave requesting.
    sys_rstn      = 1'b0;
    bus.slave_req = 4'hF;
    bus.ready     = 1'b1;
    cyc();
    cyc();
    smp();
    chk("rst_valid", 64'(bus.slave_valid), 64'(4'b0));
    chk("rst_ren",   64'(bus.slave_ren), 64'(4'b0));
    chk("rst_wen",   64'(bus.mem_wen), 64'(1'b0));
    chk("rst_addr",  64'(bus.arb_wddr_addr), 64'(23'h0));
    chk("rst_len",   64'(bus.arb_wddr_len), 64'(10'h0));
    chk("rst_data",  64'(bus.ddr_rfifo_data), 64'(32'h0));
    do_reset();

    // Single request from slave 2: per-cycle inputs and expected outputs.
    tbl[0]  = mk(4'b0100, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 23'h0,    10'd0, 32'h0);
    tbl[1]  = mk(4'b0000, 1, 0, 0, 0, 4'b0100, 4'b0000, 0, 23'h1000, 10'd8, 32'hD000_0002);
    tbl[2]  = mk(4'b0000, 1, 1, 0, 0, 4'b0100, 4'b0000, 1, 23'h1000, 10'd8, 32'hD000_0002);
    tbl[3]  = mk(4'b0000, 1, 0, 0, 0, 4'b0100, 4'b0000, 0, 23'h1000, 10'd8, 32'hD000_0002);
    for (int k = 4; k < 12; k++)
      tbl[k] = mk(4'b0000, 1, 0, 1, 0, 4'b0100, 4'b0100, 0, 23'h1000, 10'd8, 32'hD000_0002);
    tbl[12] = mk(4'b0000, 1, 0, 1, 0, 4'b0100, 4'b0000, 0, 23'h1000, 10'd8, 32'hD000_0002);
    tbl[13] = mk(4'b0000, 1, 0, 1, 0, 4'b0100, 4'b0000, 0, 23'h1000, 10'd8, 32'hD000_0002);
    tbl[14] = mk(4'b0000, 1, 0, 0, 1, 4'b0100, 4'b0000, 0, 23'h1000, 10'd8, 32'hD000_0002);
    tbl[15] = mk(4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 23'h0,    10'd0, 32'h0);

    n_ren = 0;
    for (int k = 0; k < 16; k++) begin
      bus.slave_req        = tbl[k].req;
      bus.ready            = tbl[k].rdy;
      bus.mem_wen_valid    = tbl[k].wval;
      bus.ddr_rfifo_en     = tbl[k].rfen;
      bus.ddr_write_finish = tbl[k].fin;
      smp();
      chk($sformatf("t%0d_valid", k), 64'(bus.slave_valid), 64'(tbl[k].e_valid));
      chk($sformatf("t%0d_ren", k),   64'(bus.slave_ren), 64'(tbl[k].e_ren));
      chk($sformatf("t%0d_wen", k),   64'(bus.mem_wen), 64'(tbl[k].e_wen));
      chk($sformatf("t%0d_addr", k),  64'(bus.arb_wddr_addr), 64'(tbl[k].e_addr));
      chk($sformatf("t%0d_len", k),   64'(bus.arb_wddr_len), 64'(tbl[k].e_len));
      chk($sformatf("t%0d_data", k),  64'(bus.ddr_rfifo_data), 64'(tbl[k].e_data));
      if (bus.slave_ren[2]) n_ren++;
      cyc();
    end
    chk("t_ren_pulses", 64'(n_ren), 64'(8));

    // All four requesting continuously: grant order.
    do_reset();
    bus.slave_req = 4'hF;
    bus.ready     = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_oh = 4'(1 << (k % 4));
`else
      exp_oh = 4'b0001;
`endif
      reach_burst(exp_oh, $sformatf("order%0d", k));
      finish_burst($sformatf("order%0d", k));
    end

    // ready low for 20 cycles after grant.
    do_reset();
    bus.slave_req = 4'b0010;
    smp();
    cyc();
    smp();
    chk("b_grant", 64'(bus.slave_valid), 64'(4'b0010));
    bus.slave_req = '0;
    bad = bus.mem_wen ? 1 : 0;
    for (int i = 1; i < 20; i++) begin
      cyc();
      smp();
      if (bus.mem_wen) bad++;
    end
    chk("b_wen_while_not_ready", 64'(bad), 64'(0));
    cyc();
    bus.ready = 1'b1;
    smp();
    chk("b_wen_ready_cycle", 64'(bus.mem_wen), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      cyc();
      smp();
      chk($sformatf("b_wen_hold%0d", i), 64'(bus.mem_wen), 64'(1'b1));
    end
    bus.mem_wen_valid = 1'b1;
    cyc();
    bus.mem_wen_valid = 1'b0;
    smp();
    chk("b_wen_fall", 64'(bus.mem_wen), 64'(1'b0));
    cyc();
    finish_burst("b");

    // Zero-length slave 1 is masked; slave 3 wins.
    do_reset();
    bus.slave_wlen = {10'd4, 10'd8, 10'd0, 10'd5};
    bus.slave_req  = 4'b1010;
    bus.ready      = 1'b1;
    reach_burst(4'b1000, "c_grant");
    bus.slave_req = 4'b0010;
    finish_burst("c");
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      smp();
      if (bus.slave_valid != 4'b0) bad++;
      cyc();
    end
    chk("c_zero_len_never", 64'(bad), 64'(0));
    bus.slave_wlen = {10'd4, 10'd8, 10'd6, 10'd5};

    // Finish during ISSUE, together with a command accept.
    do_reset();
    bus.slave_req = 4'b0001;
    bus.ready     = 1'b1;
    bad = 0;
    smp();
    cyc();
    bus.slave_req = '0;
    smp();
    chk("d_grant", 64'(bus.slave_valid), 64'(4'b0001));
    cyc();
    smp();
    chk("d_wen", 64'(bus.mem_wen), 64'(1'b1));
    if (bus.slave_ren != 4'b0) bad++;
    bus.ddr_write_finish = 1'b1;
    bus.mem_wen_valid    = 1'b1;
    bus.ddr_rfifo_en     = 1'b1;
    if (bus.slave_ren != 4'b0) bad++;
    cyc();
    bus.ddr_write_finish = 1'b0;
    bus.mem_wen_valid    = 1'b0;
    smp();
    chk("d_wen_cleared", 64'(bus.mem_wen), 64'(1'b0));
    chk("d_valid",       64'(bus.slave_valid), 64'(4'b0));
    chk("d_addr",        64'(bus.arb_wddr_addr), 64'(23'h0));
    chk("d_len",         64'(bus.arb_wddr_len), 64'(10'h0));
    chk("d_data",        64'(bus.ddr_rfifo_data), 64'(32'h0));
    if (bus.slave_ren != 4'b0) bad++;
    cyc();
    smp();
    if (bus.slave_ren != 4'b0) bad++;
    chk("d_no_ren", 64'(bad), 64'(0));
    chk("d_stay_idle", 64'(bus.slave_valid), 64'(4'b0));
    bus.ddr_rfifo_en = 1'b0;

    // Reset mid-burst, then re-arbitration from slave 0.
    do_reset();
    bus.slave_req = 4'hF;
    bus.ready     = 1'b1;
    reach_burst(4'b0001, "e_g0");
    finish_burst("e_g0");
`ifdef ARB_ROUND_ROBIN_EN
    reach_burst(4'b0010, "e_g1");
`else
    reach_burst(4'b0001, "e_g1");
`endif
    bus.ddr_rfifo_en = 1'b1;
    smp();
    chk("e_ren_active", 64'(bus.slave_ren != 4'b0), 64'(1'b1));
    cyc();
    sys_rstn = 1'b0;
    cyc();
    sys_rstn = 1'b1;
    smp();
    chk("e_valid", 64'(bus.slave_valid), 64'(4'b0));
    chk("e_ren",   64'(bus.slave_ren), 64'(4'b0));
    chk("e_wen",   64'(bus.mem_wen), 64'(1'b0));
    chk("e_addr",  64'(bus.arb_wddr_addr), 64'(23'h0));
    chk("e_len",   64'(bus.arb_wddr_len), 64'(10'h0));
    chk("e_data",  64'(bus.ddr_rfifo_data), 64'(32'h0));
    cyc();
    smp();
    chk("e_regrant", 64'(bus.slave_valid), 64'(4'b0001));
    chk("e_regrant_addr", 64'(bus.arb_wddr_addr), 64'(23'h0400));
    cyc();
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_wr_arbiter.md
# ddr_wr_arbiter

Parametrised N-channel write arbiter between slave write FIFOs (camera, Ethernet, etc.) and the DDR write controller. Selects one requesting slave, registers its burst address/length, handshakes the write command with the controller, muxes the controller's FIFO-read strobe and data to the granted slave, and counts beats so a slave FIFO is never over-read. Supports round-robin or fixed-priority arbitration and any slave count from 2 to 16.

## Interface
- SLAVE_NUM, 4: number of slave channels (2..16).
- ADDR_W, 23: DDR word address width.
- LEN_W, 10: burst length width, in beats.
- DATA_W, 32: write data width.

- ddr_clk  in  1  sole clock; everything is on the rising edge.
- sys_rstn  in  1  synchronous, active-low reset.
- slave_req  in  SLAVE_NUM  per-slave burst request, level; held until granted.
- slave_waddr  in  SLAVE_NUM*ADDR_W  packed start addresses; slave i at [i*ADDR_W +: ADDR_W].
- slave_wlen  in  SLAVE_NUM*LEN_W  packed burst lengths.
- slave_data  in  SLAVE_NUM*DATA_W  packed FIFO read data.
- slave_ren  out  SLAVE_NUM  FIFO read enable; only the granted bit can be high.
- slave_valid  out  SLAVE_NUM  one-hot grant, registered.
- ready  in  1  controller can accept a command.
- mem_wen  out  1  command strobe, held until mem_wen_valid.
- mem_wen_valid  in  1  controller accepted the command.
- arb_wddr_addr  out  ADDR_W  registered address of the granted slave.
- arb_wddr_len  out  LEN_W  registered length of the granted slave.
- ddr_rfifo_en  in  1  controller data pull strobe.
- ddr_rfifo_data  out  DATA_W  granted slave's data; 0 when no grant.
- ddr_write_finish  in  1  one-cycle burst-complete pulse.

## Operation
- FSM states: IDLE -> WAIT_RDY -> ISSUE -> BURST -> IDLE.
- IDLE:
  - A slave is eligible when its req=1 and its wlen != 0. Zero-length requests are masked and never granted.
  - If any slave is eligible: latch the winner's addr and len, set slave_valid to the one-hot winner, clear the beat counter, and go to WAIT_RDY.
- WAIT_RDY: when ready=1, set mem_wen=1 and go to ISSUE.
- ISSUE: hold mem_wen until mem_wen_valid=1, then clear it and go to BURST.
- BURST: slave_ren[g] = ddr_rfifo_en && (beat_cnt < arb_wddr_len). Each issued ren increments beat_cnt (LEN_W+1 bits, saturating).
- Completion: ddr_write_finish in any non-IDLE state forces IDLE on the next edge and clears slave_valid, arb_wddr_addr, arb_wddr_len, mem_wen and beat_cnt. An early finish aborts the burst.
- Simultaneous events:
  - mem_wen_valid and ddr_write_finish in the same cycle: finish wins.
  - ready in the same cycle as the grant: it is ignored. mem_wen rises no earlier than the first WAIT_RDY cycle.
- slave_ren and ddr_rfifo_data are combinational from the registered grant. slave_ren is 0 outside BURST.
- ddr_rfifo_en while beat_cnt == len is dropped and is not counted.
- Reset mid-burst: all outputs return to their reset values on the next edge. Slaves keep their requests and re-arbitrate afterwards.

## Timing
- Reset values: slave_valid=0, slave_ren=0, mem_wen=0, arb_wddr_addr=0, arb_wddr_len=0, ddr_rfifo_data=0, state=IDLE.
- Request seen in IDLE at cycle T: grant, addr and len are visible at T+1.
- With ready=1 throughout: mem_wen rises at T+2.
- mem_wen falls one cycle after mem_wen_valid.
- After finish there is at least one IDLE cycle before the next grant.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Priority rotates; the search starts at (last winner + 1) mod SLAVE_NUM.
  - The last-winner pointer resets to SLAVE_NUM-1, so slave 0 has first priority.
  - The pointer updates only on grant.
- Not defined: fixed priority; the lowest index wins. No pointer register is built.

## Structure
- Package ddr_arb_pkg holds:
  - the FSM state enum (IDLE, WAIT_RDY, ISSUE, BURST);
  - default width constants;
  - a one-hot-to-index function.
- One sub-module, arb_rr_picker: purely combinational. It takes the eligible mask and the start pointer and returns a one-hot winner plus its index. The round-robin and fixed-priority modes differ only in the start pointer fed to it.

## Test plan
- Single request: slave2 req, addr 0x1000, len 8, ready=1 → slave_valid=4'b0100 at T+1, mem_wen at T+2, exactly 8 slave_ren[2] pulses for 10 ddr_rfifo_en pulses.
- All four requesting continuously with round-robin enabled → grant order 0,1,2,3,0. With the macro off → 0,0,0.
- ready held low for 20 cycles after grant → mem_wen stays 0; it rises the cycle after ready goes high and holds until mem_wen_valid.
- slave1 len=0 and slave3 len=4 both requesting → slave3 is granted and slave1 is never granted.
- ddr_write_finish during ISSUE → IDLE next cycle, mem_wen=0, all grant outputs are 0, no slave_ren was issued.
- sys_rstn low for one cycle mid-BURST → all outputs are 0 next cycle. Requests still pending are re-granted afterwards starting from slave 0.
